// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with dual write ports, optional
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module regfile_mp_sb #(
  parameter  int WIDTH    = 32,
  parameter  int NREG     = 32,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int SELW     = $clog2(NREG)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   wen0,
  input  logic [SELW-1:0]        wsel0,
  input  logic [WIDTH-1:0]       wdat0,
  input  logic                   wen1,
  input  logic [SELW-1:0]        wsel1,
  input  logic [WIDTH-1:0]       wdat1,
  input  logic [NREAD*SELW-1:0]  rsel,
  output logic [NREAD*WIDTH-1:0] rdat,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   issue_en,
  input  logic [SELW-1:0]        issue_sel,
  output logic [SELW:0]          busy_cnt
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [SELW:0]    busy_cnt_q;
  logic [SELW:0]    busy_cnt_d;

  logic [SELW-1:0]    rsel_s  [NREAD];
  logic [NREAD*WIDTH-1:0] rdat_s;
  logic [NREAD-1:0]   rbusy_s;

  function automatic logic [SELW:0] popcount(input logic [NREG-1:0] v);
    logic [SELW:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + {{SELW{1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic is_zero_reg(input logic [SELW-1:0] sel);
    return (ZERO_REG != 0) && (sel == '0);
  endfunction

  // Storage next state: port 1 overrides port 0 on a shared address
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (is_zero_reg(SELW'(i))) begin
        regs_d[i] = '0;
      end else if (wen1 && (wsel1 == SELW'(i))) begin
        regs_d[i] = wdat1;
      end else if (wen0 && (wsel0 == SELW'(i))) begin
        regs_d[i] = wdat0;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Scoreboard next state: a new issue supersedes a same-cycle writeback
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (is_zero_reg(SELW'(i))) begin
        busy_d[i] = 1'b0;
      end else if (issue_en && (issue_sel == SELW'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wen0 && (wsel0 == SELW'(i))) || (wen1 && (wsel1 == SELW'(i)))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_cnt_d = popcount(busy_d);
  end

  // State registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Unpack the flat read-select bus
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      rsel_s[k] = rsel[k*SELW +: SELW];
    end
  end

  // Read ports; the zero register beats bypass, and a writeback only hides
  // the busy flag when no new producer targets the same register
  always_comb begin
    rdat_s  = '0;
    rbusy_s = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (is_zero_reg(rsel_s[k])) begin
        rdat_s[k*WIDTH +: WIDTH] = '0;
      end else if ((BYPASS != 0) && wen1 && (wsel1 == rsel_s[k])) begin
        rdat_s[k*WIDTH +: WIDTH] = wdat1;
      end else if ((BYPASS != 0) && wen0 && (wsel0 == rsel_s[k])) begin
        rdat_s[k*WIDTH +: WIDTH] = wdat0;
      end else begin
        rdat_s[k*WIDTH +: WIDTH] = regs_q[rsel_s[k]];
      end

      if ((BYPASS != 0)
          && ((wen0 && (wsel0 == rsel_s[k])) || (wen1 && (wsel1 == rsel_s[k])))
          && !(issue_en && (issue_sel == rsel_s[k]))) begin
        rbusy_s[k] = 1'b0;
      end else begin
        rbusy_s[k] = busy_q[rsel_s[k]];
      end
    end
  end

  assign rdat     = rdat_s;
  assign rbusy    = rbusy_s;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Adds a configurable register count, data width and read-port count, plus a second write port for dual writeback.
- Optional write-to-read bypass and a per-register busy scoreboard, which the pipelined datapath uses for hazard detection.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- WIDTH, 32, data width in bits.
- NREG, 32, register count; power of two, at least 2.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read.
- SELW is a localparam equal to $clog2(NREG).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- wen0  in  1  write enable, port 0.
- wsel0  in  SELW  write address, port 0.
- wdat0  in  WIDTH  write data, port 0.
- wen1  in  1  write enable, port 1 (higher priority).
- wsel1  in  SELW  write address, port 1.
- wdat1  in  WIDTH  write data, port 1.
- rsel  in  NREAD*SELW  read addresses; port k occupies bits [k*SELW +: SELW].
- rdat  out  NREAD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
- rbusy  out  NREAD  busy flag of the register addressed by each read port.
- issue_en  in  1  marks register issue_sel as having a pending producer.
- issue_sel  in  SELW  destination register being issued.
- busy_cnt  out  SELW+1  number of registers currently busy (registered).

Behaviour:
- Interface: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset: all registers, all busy bits and busy_cnt clear to 0 immediately on nRST low, independent of CLK. rdat and rbusy are therefore 0 while in reset.
- Writes: registered, one-cycle latency. reg[wselN] takes wdatN at the edge where wenN=1.
- Both write ports to the same register in one cycle: port 1 wins; port 0 data is discarded.
- ZERO_REG=1: writes to address 0 are dropped, rdat for address 0 is always 0, and busy bit 0 is never set.
- Reads: combinational from rsel.
- BYPASS=1: if a read address equals an enabled write address in the same cycle, rdat returns that wdat, with port 1 taking priority over port 0. The zero-register rule overrides bypass.
- BYPASS=0: rdat returns the stored value; new data is visible the cycle after the write.
- Scoreboard, each edge:
  - Busy bits clear for each enabled write address.
  - The busy bit sets for issue_sel when issue_en=1.
  - Same register issued and written in the same cycle: set wins, because the new producer supersedes the old one.
  - Issue to an already-busy register leaves it busy with no error.
  - A write to a non-busy register is a legal clear with no effect.
- rbusy[k]: reflects the registered busy bit of rsel[k], combinationally. When BYPASS=1 and a matching write clears that register this cycle, rbusy[k] reads 0, unless issue_en also targets the same register.
- busy_cnt: registered population count of the busy bits, updated on the same edge as the bits. Range is 0..NREG, or 0..NREG-1 when ZERO_REG=1.
- Out-of-range addresses are not possible, because NREG is a power of two.
- No internal FSM beyond the storage and busy arrays. The block never stalls; the consumer decides hazards from rbusy.

Test Plan:
- Reset: load reg5=0xDEADBEEF and set busy on 5, then pulse nRST low mid-cycle -> rdat for sel 5 is 0, rbusy 0 and busy_cnt 0 with no clock edge.
- Dual write conflict: wen0/wen1 both target reg7 with 0x11111111 and 0x22222222 -> next cycle rdat(sel 7) = 0x22222222. Separately, wen0 alone to reg0 with 0xFFFFFFFF -> rdat(sel 0) = 0.
- Bypass: BYPASS=1, same cycle wen1 reg3=0xA5A5A5A5 with rsel0=3 -> rdat port 0 = 0xA5A5A5A5 in that cycle. With BYPASS=0 -> old value, then 0xA5A5A5A5 the next cycle.
- Scoreboard:
  - Issue reg9 -> rbusy for sel 9 = 1 next cycle, busy_cnt=1.
  - Writeback reg9 -> rbusy clears and busy_cnt=0.
  - Issue and writeback reg9 in the same cycle -> remains busy, busy_cnt=1.
- Params NREAD=4, WIDTH=16, NREG=8: write reg i = i*0x0101 for i = 1..7, read all four ports with distinct selects -> each port returns its own value; busy_cnt width is 4 bits.
